// File: rtl/twoone_mux_pkg.sv
// Shared definitions for the 2:1 mux family: arbiter state encoding,
// mux select encoding and a helper for sizing the grant-tenure counter.
package twoone_mux_pkg;

    // Arbiter state encoding, shared with other mux-family blocks.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_A = 2'd1;
    localparam logic [1:0] GNT_B = 2'd2;

    // Mux select encoding: 0 routes input a, 1 routes input b.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_GNT_A = GNT_A,
        ST_GNT_B = GNT_B
    } arb_state_t;

    // Tenure counter width: clog2(max_hold), never less than one bit.
    function automatic int hold_width(input int max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

endpackage

// File: rtl/twoone_mux_conditional.sv
// Plain combinational 2:1 mux: y follows a when sel is SEL_A, b when SEL_B.
module twoone_mux_conditional
    import twoone_mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // Select between the two data inputs.
    always_comb begin
        y = (sel == SEL_B) ? b : a;
    end

endmodule

// File: rtl/twoone_mux_arbiter.sv
// Round-robin arbiter owning a shared 2:1 mux datapath.
//
// Handshake: a requester holds req_x high for as long as it wants the
// datapath; gnt_x (registered) says it owns the mux this cycle. Data
// presented on data_x during a cycle with gnt_x=1 appears on y after the
// next edge with y_valid=1; y is meaningful only while y_valid=1. A
// requester keeps its grant while req_x stays high, unless the other side
// is waiting and MAX_HOLD consecutive grant cycles have elapsed.
module twoone_mux_arbiter
    import twoone_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    localparam int HW = hold_width(MAX_HOLD);
    // MAX_HOLD = 0 disables preemption; the counter then just saturates.
    localparam bit PREEMPT_EN = (MAX_HOLD > 0);
    localparam logic [HW-1:0] HOLD_LAST =
        (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : {HW{1'b1}};

    arb_state_t       state;
    arb_state_t       next_state;
    logic             last;       // side granted most recently (SEL_A / SEL_B)
    logic [HW-1:0]    hold_cnt;   // grant cycles kept beyond the first
    logic             hold_done;
    logic [WIDTH-1:0] mux_y;

    assign hold_done = PREEMPT_EN && (hold_cnt == HOLD_LAST);

    // Grants come straight from the state register, so they are registered.
    assign gnt_a = (state == ST_GNT_A);
    assign gnt_b = (state == ST_GNT_B);

    // The registered select steers the shared mux; in a grant state it
    // always matches the owning side.
    twoone_mux_conditional #(
        .WIDTH(WIDTH)
    ) u_mux (
        .a   (data_a),
        .b   (data_b),
        .sel (sel),
        .y   (mux_y)
    );

    // Next-state arbitration: round robin on ties, drop or preempt hands over.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req_a && req_b)
                    next_state = (last == SEL_A) ? ST_GNT_B : ST_GNT_A;
                else if (req_a)
                    next_state = ST_GNT_A;
                else if (req_b)
                    next_state = ST_GNT_B;
                else
                    next_state = ST_IDLE;
            end
            ST_GNT_A: begin
                if (!req_a)
                    next_state = req_b ? ST_GNT_B : ST_IDLE;
                else if (req_b && hold_done)
                    next_state = ST_GNT_B;
                else
                    next_state = ST_GNT_A;
            end
            ST_GNT_B: begin
                if (!req_b)
                    next_state = req_a ? ST_GNT_A : ST_IDLE;
                else if (req_a && hold_done)
                    next_state = ST_GNT_A;
                else
                    next_state = ST_GNT_B;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State, round-robin pointer, tenure counter, select and output data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            last     <= SEL_B;
            hold_cnt <= '0;
            sel      <= SEL_A;
            y        <= '0;
            y_valid  <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != ST_IDLE) begin
                sel <= (next_state == ST_GNT_B) ? SEL_B : SEL_A;
                if (next_state != state) begin
                    // Fresh grant: restart tenure and move the pointer.
                    last     <= (next_state == ST_GNT_B) ? SEL_B : SEL_A;
                    hold_cnt <= '0;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
            if (state != ST_IDLE) begin
                y       <= mux_y;
                y_valid <= 1'b1;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_twoone_mux_arbiter.sv
// Bench for twoone_mux_arbiter: one instance with MAX_HOLD=4 and one with
// MAX_HOLD=0 share the same stimulus. Each is compared every cycle against
// an ownership/tenure model; a constant vector table and hand sequences
// cover reset, single requester, round robin, preemption and reset mid-grant.
module tb_twoone_mux_arbiter;

    localparam int WIDTH = 8;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus / DUT signals ----------------
    logic             rst = 1'b1;
    logic             req_a = 1'b0;
    logic             req_b = 1'b0;
    logic [WIDTH-1:0] data_a = '0;
    logic [WIDTH-1:0] data_b = '0;

    logic             ga4, gb4, sel4, yv4;
    logic [WIDTH-1:0] y4;
    logic             ga0, gb0, sel0, yv0;
    logic [WIDTH-1:0] y0;

    twoone_mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
        .data_a(data_a), .data_b(data_b),
        .gnt_a(ga4), .gnt_b(gb4), .sel(sel4), .y(y4), .y_valid(yv4)
    );

    twoone_mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(0)) dut0 (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
        .data_a(data_a), .data_b(data_b),
        .gnt_a(ga0), .gnt_b(gb0), .sel(sel0), .y(y0), .y_valid(yv0)
    );

    // ---------------- bookkeeping ----------------
    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: 0 = nobody, 1 = A, 2 = B. tenure counts cycles the current
    // owner has held the datapath so far (1 in its first grant cycle).
    int               m_hold[2] = '{4, 0};
    int               m_owner[2];
    int               m_ten[2];
    int               m_last[2];
    logic             m_sel[2];
    logic [WIDTH-1:0] m_y[2];
    logic             m_yv[2];

    task automatic model_edge(input int k);
        int nxt;
        int other;
        bit own_req;
        bit oth_req;
        if (rst) begin
            m_owner[k] = 0; m_ten[k] = 0; m_last[k] = 2;
            m_sel[k] = 1'b0; m_y[k] = '0; m_yv[k] = 1'b0;
            return;
        end
        // Data: whatever the owner presents now is captured.
        if (m_owner[k] != 0) begin
            m_y[k]  = (m_owner[k] == 1) ? data_a : data_b;
            m_yv[k] = 1'b1;
        end else begin
            m_yv[k] = 1'b0;
        end
        // Who owns the datapath next.
        if (m_owner[k] == 0) begin
            if (req_a && req_b) nxt = (m_last[k] == 1) ? 2 : 1;
            else if (req_a)     nxt = 1;
            else if (req_b)     nxt = 2;
            else                nxt = 0;
        end else begin
            other   = 3 - m_owner[k];
            own_req = (m_owner[k] == 1) ? req_a : req_b;
            oth_req = (m_owner[k] == 1) ? req_b : req_a;
            if (own_req && !(oth_req && m_hold[k] > 0 && m_ten[k] >= m_hold[k]))
                nxt = m_owner[k];
            else if (oth_req)
                nxt = other;
            else
                nxt = 0;
        end
        if (nxt != 0 && nxt == m_owner[k]) m_ten[k]++;
        else if (nxt != 0) begin
            m_ten[k]  = 1;
            m_last[k] = nxt;
        end
        if (nxt != 0) m_sel[k] = (nxt == 2);
        m_owner[k] = nxt;
    endtask

    task automatic check_model(input int k, input logic ga, input logic gb,
                               input logic s, input logic [WIDTH-1:0] yy,
                               input logic v);
        string p;
        p = (k == 0) ? "mh4" : "mh0";
        check({p, ".gnt_a"},   WIDTH'(ga), WIDTH'(m_owner[k] == 1));
        check({p, ".gnt_b"},   WIDTH'(gb), WIDTH'(m_owner[k] == 2));
        check({p, ".sel"},     WIDTH'(s),  WIDTH'(m_sel[k]));
        check({p, ".y"},       yy,         m_y[k]);
        check({p, ".y_valid"}, WIDTH'(v),  WIDTH'(m_yv[k]));
        check({p, ".mutex"},   WIDTH'(ga & gb), '0);
    endtask

    // ---------------- driver ----------------
    // Apply one cycle of inputs, advance the models, then sample 1ns later.
    task automatic step(input logic r, input logic ra, input logic rb,
                        input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        rst = r; req_a = ra; req_b = rb; data_a = da; data_b = db;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_model(0, ga4, gb4, sel4, y4, yv4);
        check_model(1, ga0, gb0, sel0, y0, yv0);
    endtask

    // ---------------- vector table (MAX_HOLD=4 instance) ----------------
    typedef struct {
        logic             r, ra, rb;
        logic [WIDTH-1:0] da, db;
        logic             ga, gb, s;
        logic [WIDTH-1:0] y;
        logic             yv;
    } vec_t;

    vec_t vecs[17];

    initial begin
        //         rst ra rb  da     db     ga gb sel y      yv
        vecs[0]  = '{1, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00, 0};
        vecs[1]  = '{1, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00, 0};
        vecs[2]  = '{0, 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'h00, 0};
        vecs[3]  = '{0, 0, 0, 8'h33, 8'h22, 0, 0, 0, 8'h33, 1};
        vecs[4]  = '{0, 0, 0, 8'h44, 8'h22, 0, 0, 0, 8'h33, 0};
        vecs[5]  = '{0, 1, 0, 8'hA5, 8'h22, 1, 0, 0, 8'h33, 0};
        vecs[6]  = '{0, 1, 0, 8'hA5, 8'h22, 1, 0, 0, 8'hA5, 1};
        vecs[7]  = '{0, 1, 0, 8'hA5, 8'h22, 1, 0, 0, 8'hA5, 1};
        vecs[8]  = '{0, 0, 0, 8'hA5, 8'h22, 0, 0, 0, 8'hA5, 1};
        vecs[9]  = '{0, 0, 0, 8'h5A, 8'h22, 0, 0, 0, 8'hA5, 0};
        vecs[10] = '{0, 1, 1, 8'h01, 8'h02, 0, 1, 1, 8'hA5, 0};
        vecs[11] = '{0, 1, 1, 8'h01, 8'h02, 0, 1, 1, 8'h02, 1};
        vecs[12] = '{0, 1, 0, 8'h01, 8'h02, 1, 0, 0, 8'h02, 1};
        vecs[13] = '{0, 1, 1, 8'h01, 8'h02, 1, 0, 0, 8'h01, 1};
        vecs[14] = '{0, 0, 1, 8'h01, 8'h03, 0, 1, 1, 8'h01, 1};
        vecs[15] = '{0, 0, 0, 8'h01, 8'h03, 0, 0, 1, 8'h03, 1};
        vecs[16] = '{0, 0, 0, 8'h01, 8'h03, 0, 0, 1, 8'h03, 0};
    end

    // ---------------- main sequence ----------------
    initial begin
        #2;
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].r, vecs[i].ra, vecs[i].rb, vecs[i].da, vecs[i].db);
            check($sformatf("vec%0d.gnt_a", i),   WIDTH'(ga4),  WIDTH'(vecs[i].ga));
            check($sformatf("vec%0d.gnt_b", i),   WIDTH'(gb4),  WIDTH'(vecs[i].gb));
            check($sformatf("vec%0d.sel", i),     WIDTH'(sel4), WIDTH'(vecs[i].s));
            check($sformatf("vec%0d.y", i),       y4,           vecs[i].y);
            check($sformatf("vec%0d.y_valid", i), WIDTH'(yv4),  WIDTH'(vecs[i].yv));
        end

        // Continuous tie: MAX_HOLD=4 alternates in blocks of four,
        // MAX_HOLD=0 keeps A for the whole run.
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 1'b1, 8'(k), 8'(8'h80 + k));
            check($sformatf("preempt%0d.gnt_a", k), WIDTH'(ga4), WIDTH'(((k / 4) % 2) == 0));
            check($sformatf("nohold%0d.gnt_a", k),  WIDTH'(ga0), WIDTH'(1));
        end
        // A releases: B follows immediately on both instances.
        step(1'b0, 1'b0, 1'b1, 8'h10, 8'hB0);
        check("release.mh0.gnt_b", WIDTH'(gb0), WIDTH'(1));
        check("release.mh4.gnt_b", WIDTH'(gb4), WIDTH'(1));

        // Reset while B owns the datapath, then a tie goes to A.
        step(1'b1, 1'b1, 1'b1, 8'h21, 8'hB1);
        check("midrst.gnt_b",   WIDTH'(gb4),  WIDTH'(0));
        check("midrst.sel",     WIDTH'(sel4), WIDTH'(0));
        check("midrst.y",       y4,           WIDTH'(0));
        check("midrst.y_valid", WIDTH'(yv4),  WIDTH'(0));
        step(1'b0, 1'b1, 1'b1, 8'h22, 8'hB2);
        check("midrst.tie_a",   WIDTH'(ga4),  WIDTH'(1));

        // Random traffic, occasional resets, both instances against the model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        // Long contested stretch to exercise repeated preemption.
        for (int n = 0; n < 40; n++) begin
            step(1'b0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
